// File: rtl/regfile_pkg.sv
// Shared register-file definitions: the project-wide bus/size macros
// (REG_ADDR_BUS, REG_BUS, REG_NUM, ZERO_WORD) plus a small helper package.
// Optional feature macro: RF_BYPASS_EN (write-to-read forwarding).
`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif
`ifndef REG_BUS
`define REG_BUS 31:0
`endif
`ifndef REG_NUM
`define REG_NUM 32
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 32'h0
`endif

package regfile_pkg;

  localparam int NUM_RPORTS = 4;

  typedef logic [`REG_BUS]      word_t;
  typedef logic [`REG_ADDR_BUS] addr_t;

  // A write only lands (or forwards) when enabled and not aimed at x0.
  function automatic logic live_write(input logic we, input addr_t addr);
    return we && (addr != '0);
  endfunction

endpackage

// File: rtl/rf_rport.sv
// One register-file read port: array select, x0 forced to zero and,
// when RF_BYPASS_EN is defined, same-cycle forwarding with slot 2 winning.
module rf_rport
  import regfile_pkg::*;
(
  input  logic [`REG_ADDR_BUS]            raddr,
  input  logic [`REG_NUM-1:0][`REG_BUS]   regs,
  output logic [`REG_BUS]                 rdata
`ifdef RF_BYPASS_EN
  ,
  input  logic                            we1,
  input  logic [`REG_ADDR_BUS]            waddr1,
  input  logic [`REG_BUS]                 wdata1,
  input  logic                            we2,
  input  logic [`REG_ADDR_BUS]            waddr2,
  input  logic [`REG_BUS]                 wdata2
`endif
);

  // Select stored word, overriding with in-flight write data when forwarding.
  always_comb begin
    rdata = `ZERO_WORD;
    if (raddr != '0) begin
      rdata = regs[raddr];
`ifdef RF_BYPASS_EN
      if (live_write(we2, waddr2) && (waddr2 == raddr)) begin
        rdata = wdata2;
      end else if (live_write(we1, waddr1) && (waddr1 == raddr)) begin
        rdata = wdata1;
      end
`endif
    end
  end

endmodule

// File: rtl/regfile.sv
// Dual-write, quad-read 32x32 register file. Storage, write ordering and
// the same-address conflict flag live here; reads go through rf_rport.
// Optional feature macro: RF_BYPASS_EN (write-to-read forwarding).
module regfile
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rfwe_in1,
  input  logic [`REG_ADDR_BUS] rfwaddr_in1,
  input  logic [`REG_BUS]      rfwdata_in1,
  input  logic                 rfwe_in2,
  input  logic [`REG_ADDR_BUS] rfwaddr_in2,
  input  logic [`REG_BUS]      rfwdata_in2,
  input  logic [`REG_ADDR_BUS] rfraddr1,
  input  logic [`REG_ADDR_BUS] rfraddr2,
  input  logic [`REG_ADDR_BUS] rfraddr3,
  input  logic [`REG_ADDR_BUS] rfraddr4,
  output logic [`REG_BUS]      rfrdata1,
  output logic [`REG_BUS]      rfrdata2,
  output logic [`REG_BUS]      rfrdata3,
  output logic [`REG_BUS]      rfrdata4,
  output logic                 wr_conflict
);

  logic [`REG_NUM-1:0][`REG_BUS] regs;
  logic                          live1;
  logic                          live2;
  logic [`REG_ADDR_BUS]          raddr [NUM_RPORTS];
  logic [`REG_BUS]               rdata [NUM_RPORTS];

  assign live1 = live_write(rfwe_in1, rfwaddr_in1);
  assign live2 = live_write(rfwe_in2, rfwaddr_in2);

  // Commit both slots; slot 2 is assigned last so it wins a shared address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      if (live1) regs[rfwaddr_in1] <= rfwdata_in1;
      if (live2) regs[rfwaddr_in2] <= rfwdata_in2;
      wr_conflict <= live1 && live2 && (rfwaddr_in1 == rfwaddr_in2);
    end
  end

  assign raddr[0] = rfraddr1;
  assign raddr[1] = rfraddr2;
  assign raddr[2] = rfraddr3;
  assign raddr[3] = rfraddr4;

`ifdef RF_BYPASS_EN
  // Forwarding is suppressed in reset so every port reads zero there.
  logic byp_we1;
  logic byp_we2;
  assign byp_we1 = rfwe_in1 & rst_n;
  assign byp_we2 = rfwe_in2 & rst_n;
`endif

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
    rf_rport u_rport (
      .raddr  (raddr[p]),
      .regs   (regs),
      .rdata  (rdata[p])
`ifdef RF_BYPASS_EN
      ,
      .we1    (byp_we1),
      .waddr1 (rfwaddr_in1),
      .wdata1 (rfwdata_in1),
      .we2    (byp_we2),
      .waddr2 (rfwaddr_in2),
      .wdata2 (rfwdata_in2)
`endif
    );
  end

  assign rfrdata1 = rdata[0];
  assign rfrdata2 = rdata[1];
  assign rfrdata3 = rdata[2];
  assign rfrdata4 = rdata[3];

endmodule
